// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, LSU FSM state type and request classification helpers
package lsu_pkg;
   localparam logic [2:0] LB  = 3'd0;
   localparam logic [2:0] LH  = 3'd1;
   localparam logic [2:0] LW  = 3'd2;
   localparam logic [2:0] LBU = 3'd4;
   localparam logic [2:0] LHU = 3'd5;
   localparam logic [2:0] SB  = 3'd0;
   localparam logic [2:0] SH  = 3'd1;
   localparam logic [2:0] SW  = 3'd2;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      return we ? (f3 == SB || f3 == SH || f3 == SW)
                : (f3 == LB || f3 == LH || f3 == LW || f3 == LBU || f3 == LHU);
   endfunction
   // size lives in func3[1:0]: 0 byte, 1 halfword, 2 word
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
      return (f3[1:0] == 2'd1 && a == 2'd3) || (f3[1:0] == 2'd2 && a != 2'd0);
   endfunction
endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: sign/zero extension of right-aligned load data by funct3
//   raw_i   : right-aligned load data
//   func3_i : load funct3
//   ext_o   : extended 32-bit result (word and unknown encodings pass through)
module lsu_extend import lsu_pkg::*; (
   input  logic [31:0] raw_i,
   input  logic [2:0]  func3_i,
   output logic [31:0] ext_o
);
   always_comb
      ext_o = func3_i == LB  ? {{24{raw_i[7]}}, raw_i[7:0]} :
              func3_i == LH  ? {{16{raw_i[15]}}, raw_i[15:0]} :
              func3_i == LBU ? {24'd0, raw_i[7:0]} :
              func3_i == LHU ? {16'd0, raw_i[15:0]} : raw_i;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller with illegal-access detection and optional misaligned byte splitting
//   clk, rst                 : clock, asynchronous active-high reset
//   req_*                    : core request (valid/ready, we, addr, wdata, func3)
//   resp_valid/rdata/err     : one-cycle completion pulse with extended load data and error flag
//   mem_*                    : data-memory port, combinational read, writes commit on negedge clk
//   LSU_MISALIGN_EN          : when defined, misaligned halfword/word accesses split into byte accesses;
//                              otherwise they are reported as errors
module lsu_ctrl import lsu_pkg::*; #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [2:0]        req_func3,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_func3,
   input  logic [DATA_W-1:0] mem_rdata
);
`ifdef LSU_MISALIGN_EN
   localparam logic MIS_EN = 1'b1;
`else
   localparam logic MIS_EN = 1'b0;
`endif
   state_t            state_q, state_d;
   logic              we_q, we_d, err_q, err_d, split_q, split_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, data_q, data_d, ext;
   logic [2:0]        func3_q, func3_d;
   logic [1:0]        idx_q, idx_d, last;
   logic              mis, ill;
   assign mis  = f3_misaligned(req_func3, req_addr[1:0]);
   assign ill  = !f3_legal(req_we, req_func3) || (mis && !MIS_EN);
   assign last = func3_q[1:0] == 2'd1 ? 2'd1 : 2'd3;
   lsu_extend u_ext (
      .raw_i   (data_q),
      .func3_i (func3_q),
      .ext_o   (ext)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end
   always_comb
      state_d = state_q == IDLE   ? (req_valid ? (ill ? RESP : ACCESS) : IDLE) :
                state_q == ACCESS ? ((!split_q || idx_q == last) ? RESP : ACCESS) : IDLE;
   always_comb begin
      req_ready  = state_q == IDLE;
      mem_we     = state_q == ACCESS && we_q;
      mem_addr   = state_q == ACCESS ? addr_q + ADDR_W'(idx_q) : '0;
      mem_func3  = state_q != ACCESS ? 3'd0 : !split_q ? func3_q : we_q ? SB : LBU;
      mem_wdata  = state_q != ACCESS ? '0 : split_q ? DATA_W'(wdata_q[{idx_q, 3'b000} +: 8]) : wdata_q;
      resp_valid = state_q == RESP;
      resp_err   = resp_valid && err_q;
      resp_rdata = (resp_valid && !err_q && !we_q) ? ext : '0;
   end
   // request capture at acceptance; byte assembly during split loads
   always_comb begin
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      func3_d = func3_q;
      err_d   = err_q;
      split_d = split_q;
      idx_d   = idx_q;
      data_d  = data_q;
      if (state_q == IDLE && req_valid) begin
         we_d    = req_we;
         addr_d  = req_addr;
         wdata_d = req_wdata;
         func3_d = req_func3;
         err_d   = ill;
         split_d = mis && MIS_EN;
         idx_d   = '0;
         data_d  = '0;
      end else if (state_q == ACCESS) begin
         idx_d = idx_q + 2'd1;
         if (split_q) data_d[{idx_q, 3'b000} +: 8] = mem_rdata[7:0];
         else         data_d = mem_rdata;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         func3_q <= '0;
         err_q   <= 1'b0;
         split_q <= 1'b0;
         idx_q   <= '0;
         data_q  <= '0;
      end else begin
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         func3_q <= func3_d;
         err_q   <= err_d;
         split_q <= split_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
      end
   end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl with a byte-array data memory
module tb_lsu_ctrl;
   logic        clk = 1'b0;
   logic        rst, req_valid, req_ready, req_we, resp_valid, resp_err, mem_we;
   logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  req_func3, mem_func3;
   logic [7:0]  mem [4096];
   logic [11:0] ma;
   int          n_chk = 0, n_fail = 0, we_cnt = 0, rv_cnt = 0, c, snap;
   always #5 clk = ~clk;
   lsu_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_func3  (req_func3),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_func3  (mem_func3),
      .mem_rdata  (mem_rdata)
   );
   // memory returns the addressed bytes right-aligned and zero-padded; extension is the LSU's job
   always_comb begin
      ma        = mem_addr[11:0];
      mem_rdata = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};
      if (mem_func3[1:0] == 2'd0)      mem_rdata[31:8]  = '0;
      else if (mem_func3[1:0] == 2'd1) mem_rdata[31:16] = '0;
   end
   always @(negedge clk) begin
      if (mem_we) begin
         we_cnt <= we_cnt + 1;
         mem[mem_addr[11:0]] <= mem_wdata[7:0];
         if (mem_func3[1:0] != 2'd0) mem[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
         if (mem_func3[1:0] == 2'd2) begin
            mem[mem_addr[11:0] + 12'd2] <= mem_wdata[23:16];
            mem[mem_addr[11:0] + 12'd3] <= mem_wdata[31:24];
         end
      end
      if (resp_valid) rv_cnt <= rv_cnt + 1;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      req_we    = we;
      req_func3 = f3;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
      step;
      req_valid = 1'b0;
   endtask
   task automatic wait_resp(output int cyc);
      cyc = 0;
      while (resp_valid !== 1'b1 && cyc < 10) begin
         step;
         cyc++;
      end
   endtask
   task automatic xact(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int exp_cyc, input logic [31:0] exp_rd, input logic exp_err);
      int cyc;
      issue(we, f3, a, d);
      wait_resp(cyc);
      chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_rdata"}, resp_rdata, exp_rd);
      chk({tag, "_err"}, resp_err, exp_err);
      step;
      chk({tag, "_pulse"}, resp_valid, 1'b0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_func3 = '0;
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      mem[12'h100] <= 8'hEF;
      mem[12'h101] <= 8'hBE;
      mem[12'h102] <= 8'hAD;
      mem[12'h103] <= 8'hDE;
      step;
      step;
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_rv", resp_valid, 1'b0);
      chk("rst_err", resp_err, 1'b0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_mwe", mem_we, 1'b0);
      chk("rst_maddr", mem_addr, 32'h0);
      chk("rst_mwdata", mem_wdata, 32'h0);
      chk("rst_mf3", mem_func3, 3'd0);
      rst = 1'b0;
      step;
      issue(1'b0, 3'd2, 32'h100, 32'h0);
      chk("lw_maddr", mem_addr, 32'h100);
      chk("lw_mf3", mem_func3, 3'd2);
      chk("lw_mwe", mem_we, 1'b0);
      chk("lw_busy", req_ready, 1'b0);
      wait_resp(c);
      chk("lw_cyc", 32'(c), 32'd1);
      chk("lw_rdata", resp_rdata, 32'hDEADBEEF);
      chk("lw_err", resp_err, 1'b0);
      step;
      chk("lw_pulse", resp_valid, 1'b0);
      chk("lw_ready", req_ready, 1'b1);
      xact("lh102", 1'b0, 3'd1, 32'h102, 32'h0, 1, 32'hFFFFDEAD, 1'b0);
      xact("lhu102", 1'b0, 3'd5, 32'h102, 32'h0, 1, 32'h0000DEAD, 1'b0);
      xact("lb101", 1'b0, 3'd0, 32'h101, 32'h0, 1, 32'hFFFFFFBE, 1'b0);
      xact("lbu101", 1'b0, 3'd4, 32'h101, 32'h0, 1, 32'h000000BE, 1'b0);
      xact("sw300", 1'b1, 3'd2, 32'h300, 32'hCAFEF00D, 1, 32'h0, 1'b0);
      xact("lw300a", 1'b0, 3'd2, 32'h300, 32'h0, 1, 32'hCAFEF00D, 1'b0);
      xact("sb301", 1'b1, 3'd0, 32'h301, 32'h123456AA, 1, 32'h0, 1'b0);
      xact("lw300b", 1'b0, 3'd2, 32'h300, 32'h0, 1, 32'hCAFEAA0D, 1'b0);
      xact("sh302", 1'b1, 3'd1, 32'h302, 32'hFFFF1234, 1, 32'h0, 1'b0);
      xact("lw300c", 1'b0, 3'd2, 32'h300, 32'h0, 1, 32'h1234AA0D, 1'b0);
      snap = we_cnt;
      xact("ld_f3_3", 1'b0, 3'd3, 32'h100, 32'h0, 0, 32'h0, 1'b1);
      xact("st_f3_4", 1'b1, 3'd4, 32'h300, 32'h77, 0, 32'h0, 1'b1);
      chk("illegal_nowrite", 32'(we_cnt), 32'(snap));
      xact("lw300d", 1'b0, 3'd2, 32'h300, 32'h0, 1, 32'h1234AA0D, 1'b0);
`ifndef LSU_MISALIGN_EN
      snap = we_cnt;
      issue(1'b0, 3'd2, 32'h102, 32'h0);
      chk("mis_lw_noacc", mem_addr, 32'h0);
      wait_resp(c);
      chk("mis_lw_cyc", 32'(c), 32'd0);
      chk("mis_lw_err", resp_err, 1'b1);
      chk("mis_lw_rdata", resp_rdata, 32'h0);
      step;
      xact("mis_lh", 1'b0, 3'd1, 32'h103, 32'h0, 0, 32'h0, 1'b1);
      xact("mis_sw", 1'b1, 3'd2, 32'h201, 32'h11223344, 0, 32'h0, 1'b1);
      chk("mis_nowrite", 32'(we_cnt), 32'(snap));
      chk("mis_mem201", mem[12'h201], 8'h00);
`else
      mem[12'h103] <= 8'h80;
      mem[12'h104] <= 8'h92;
      step;
      issue(1'b0, 3'd1, 32'h103, 32'h0);
      chk("lh_sub0_addr", mem_addr, 32'h103);
      chk("lh_sub0_f3", mem_func3, 3'd4);
      step;
      chk("lh_sub1_addr", mem_addr, 32'h104);
      chk("lh_sub1_f3", mem_func3, 3'd4);
      step;
      chk("lh_rv", resp_valid, 1'b1);
      chk("lh_rdata", resp_rdata, 32'hFFFF9280);
      chk("lh_err", resp_err, 1'b0);
      step;
      xact("lhu103", 1'b0, 3'd5, 32'h103, 32'h0, 2, 32'h00009280, 1'b0);
      issue(1'b0, 3'd2, 32'h102, 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("lw102_addr%0d", i), mem_addr, 32'h102 + 32'(i));
         chk($sformatf("lw102_f3%0d", i), mem_func3, 3'd4);
         step;
      end
      chk("lw102_rv", resp_valid, 1'b1);
      chk("lw102_rdata", resp_rdata, 32'h009280AD);
      step;
      issue(1'b1, 3'd2, 32'h201, 32'h11223344);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("sw201_we%0d", i), mem_we, 1'b1);
         chk($sformatf("sw201_addr%0d", i), mem_addr, 32'h201 + 32'(i));
         chk($sformatf("sw201_f3%0d", i), mem_func3, 3'd0);
         chk($sformatf("sw201_wd%0d", i), mem_wdata, (32'h11223344 >> (8 * i)) & 32'hFF);
         step;
      end
      chk("sw201_rv", resp_valid, 1'b1);
      chk("sw201_err", resp_err, 1'b0);
      step;
      xact("lw204", 1'b0, 3'd2, 32'h204, 32'h0, 1, 32'h00000011, 1'b0);
      mem[12'hFFF] <= 8'h34;
      mem[12'h000] <= 8'h12;
      step;
      issue(1'b0, 3'd1, 32'hFFFFFFFF, 32'h0);
      chk("wrap_addr0", mem_addr, 32'hFFFFFFFF);
      step;
      chk("wrap_addr1", mem_addr, 32'h0);
      step;
      chk("wrap_rdata", resp_rdata, 32'h00001234);
      step;
      issue(1'b1, 3'd2, 32'h201, 32'h55667788);
      step;
      chk("rstmid_addr", mem_addr, 32'h202);
      @(negedge clk);
      #1;
      snap = rv_cnt;
      rst = 1'b1;
      #1;
      chk("rstmid_mwe", mem_we, 1'b0);
      chk("rstmid_rv", resp_valid, 1'b0);
      step;
      step;
      rst = 1'b0;
      step;
      chk("rstmid_ready", req_ready, 1'b1);
      chk("rstmid_noresp", 32'(rv_cnt), 32'(snap));
      chk("rstmid_m201", mem[12'h201], 8'h88);
      chk("rstmid_m202", mem[12'h202], 8'h77);
      chk("rstmid_m203", mem[12'h203], 8'h22);
`endif
      issue(1'b1, 3'd2, 32'h310, 32'hA5A5A5A5);
      chk("rstacc_mwe_before", mem_we, 1'b1);
      snap = rv_cnt;
      rst = 1'b1;
      #1;
      chk("rstacc_mwe", mem_we, 1'b0);
      chk("rstacc_rv", resp_valid, 1'b0);
      chk("rstacc_maddr", mem_addr, 32'h0);
      step;
      step;
      rst = 1'b0;
      step;
      chk("rstacc_ready", req_ready, 1'b1);
      chk("rstacc_noresp", 32'(rv_cnt), 32'(snap));
      xact("lw310", 1'b0, 3'd2, 32'h310, 32'h0, 1, 32'h0, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1: core load/store request present.
REQ-006 SHALL have port req_ready, output, 1: block accepts a request.
REQ-007 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, ADDR_W: byte address.
REQ-009 SHALL have port req_wdata, input, DATA_W: store data, right-aligned.
REQ-010 SHALL have port req_func3, input, 3: RISC-V load/store funct3.
REQ-011 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, DATA_W: extended load result; 0 for stores.
REQ-013 SHALL have port resp_err, output, 1: illegal or unsupported access, valid with resp_valid.
REQ-014 SHALL have ports mem_addr (output, ADDR_W), mem_we (output, 1), mem_wdata (output, DATA_W), mem_func3 (output, 3) and mem_rdata (input, DATA_W): data-memory port; read data is combinational; writes commit on the negedge of clk.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ACCESS and RESP.
REQ-016 SHALL assert req_ready only in IDLE; a request is accepted on a posedge with req_valid && req_ready, and all request fields are registered at that edge.
REQ-017 SHALL classify each request at acceptance:
- Legal loads: func3 0, 1, 2, 4 and 5.
- Legal stores: func3 0, 1 and 2.
- Anything else is illegal.
REQ-018 SHALL treat an access as aligned when it lies entirely within one word:
- Byte accesses are always aligned.
- Halfword accesses are aligned when addr[1:0] != 3.
- Word accesses are aligned when addr[1:0] == 0.
REQ-019 SHALL handle an aligned access as one ACCESS cycle that drives mem_addr = addr, mem_func3 = func3, mem_wdata = wdata and mem_we = we, and registers mem_rdata.
REQ-020 SHALL handle a misaligned access as N byte sub-accesses (N = 2 for halfword, 4 for word):
- Sub-access i uses address addr+i, in ascending order, one per ACCESS cycle.
- Loads use mem_func3 = 4 (lbu), and byte i of the registered result is taken from mem_rdata[7:0].
- Stores use mem_func3 = 0 (sb) with mem_wdata[7:0] = wdata byte i.
REQ-021 SHALL compute addr+i modulo 2^ADDR_W, so 0xFFFFFFFF wraps to 0x00000000.
REQ-022 SHALL assert resp_valid for exactly one cycle, in RESP, during the cycle after acceptance edge +N (N = 1 for aligned); then return to IDLE.
REQ-023 SHALL, for an illegal request, go directly to RESP with resp_err = 1, make no memory access (mem_we stays 0), and return resp_rdata = 0.
REQ-024 SHALL sign-extend the assembled misaligned load result for func3 1 and zero-extend it for func3 5; a misaligned word load is not extended.
REQ-025 SHALL hold mem_we = 0 in IDLE and RESP; mem outputs are 0 outside ACCESS.
REQ-026 SHALL ignore req_valid while not in IDLE; back-to-back requests accept at the earliest in the cycle after RESP.

Reset
REQ-027 SHALL, while rst = 1, asynchronously force:
- state to IDLE;
- req_ready = 1;
- resp_valid = 0, resp_err = 0, resp_rdata = 0;
- mem_we = 0 and all other mem_* outputs = 0;
- byte index and assembled data to 0.
REQ-028 SHALL, on reset mid-ACCESS, abandon the access without a response; byte stores already committed remain in memory.

Configuration
REQ-029 SHALL support misaligned splitting (REQ-020, REQ-024) only when LSU_MISALIGN_EN is defined.
REQ-030 SHALL, without LSU_MISALIGN_EN, treat every misaligned request as illegal per REQ-023.

Structure
REQ-031 SHALL place the func3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state type in shared package lsu_pkg.
REQ-032 SHALL place sign/zero extension in the combinational sub-module lsu_extend (inputs: raw data, func3; output: 32-bit result).

Verification
REQ-033 SHALL cover: word 0x100 = 0xDEADBEEF, lw at 0x100 -> one ACCESS cycle, resp_rdata = 0xDEADBEEF, resp_err = 0.
REQ-034 SHALL cover: bytes 0x103 = 0x80 and 0x104 = 0x92, lh at 0x103 -> lbu at 0x103 then 0x104, resp_rdata = 0xFFFF9280; the same with lhu -> 0x00009280.
REQ-035 SHALL cover: sw 0x11223344 at 0x201 -> sb 0x44@0x201, 0x33@0x202, 0x22@0x203, 0x11@0x204, resp_valid 4 cycles after acceptance, then lw at 0x204 reads 0x00000011 in the low byte.
REQ-036 SHALL cover: rst asserted during the second sb of REQ-035 -> mem_we drops at once, no resp_valid, req_ready = 1 after release, bytes 0x201 and 0x202 updated.
REQ-037 SHALL cover: load with func3 = 3, then store with func3 = 4 -> each gives resp_err = 1 one cycle after acceptance with mem_we never asserted.
REQ-038 SHALL cover: with LSU_MISALIGN_EN undefined, lw at 0x102 -> resp_err = 1 and no memory access; with it defined, 4 byte reads.
